// File: rtl/conv2d_stream.sv
// conv2d_stream: 3x3 single-channel streaming convolution with NUM_FILT parallel filters,
// frame buffer, run-time loadable weights/biases, fused bias/ReLU/shift/saturate.
module conv2d_stream #(
    parameter int IMG_W      = 8,
    parameter int IMG_H      = 8,
    parameter int NUM_FILT   = 2,
    parameter int PAD        = 1,
    parameter int BIAS_SHIFT = 11,
    parameter int OUT_SHIFT  = 3,
    parameter int ACC_W      = 24
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [7:0]                      s_data,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [8*NUM_FILT-1:0]           m_data,
    output logic                            m_last,
    output logic                            busy,
    input  logic                            cfg_we,
    input  logic [$clog2(10*NUM_FILT)-1:0]  cfg_addr,
    input  logic [7:0]                      cfg_data
);
    localparam int NPIX = IMG_W * IMG_H;
    localparam int AW   = $clog2(NPIX);
    localparam int XW   = $clog2(IMG_W);
    localparam int YW   = $clog2(IMG_H);
    localparam int CAW  = $clog2(10 * NUM_FILT);
    localparam int OW   = (PAD != 0) ? IMG_W : IMG_W - 2;
    localparam int OH   = (PAD != 0) ? IMG_H : IMG_H - 2;

    typedef enum logic [1:0] {LOAD, MAC, EMIT} state_t;

    state_t                  state_q, state_d;
    logic [AW-1:0]           pcnt_q, pcnt_d;
    logic [XW-1:0]           cx_q, cx_d;
    logic [YW-1:0]           cy_q, cy_d;
    logic [3:0]              k_q, k_d;
    logic [1:0]              kx_q, kx_d, ky_q, ky_d;
    logic signed [7:0]       w_q [NUM_FILT][9];
    logic signed [7:0]       w_d [NUM_FILT][9];
    logic signed [7:0]       b_q [NUM_FILT];
    logic signed [7:0]       b_d [NUM_FILT];
    logic signed [ACC_W-1:0] acc_q [NUM_FILT];
    logic signed [ACC_W-1:0] acc_d [NUM_FILT];
    logic signed [ACC_W-1:0] acc_sum [NUM_FILT];
    logic signed [16:0]      prod [NUM_FILT];
    logic signed [ACC_W-1:0] v, q;
    logic [8*NUM_FILT-1:0]   res;
    logic                    s_ready_q, s_ready_d, m_valid_q, m_valid_d, m_last_q, m_last_d;
    logic                    busy_q, busy_d;
    logic [8*NUM_FILT-1:0]   m_data_q, m_data_d;
    logic [7:0]              fb_mem [NPIX];
    int                      px, py;
    logic                    in_frame, wr, last_pix, last_pos;
    logic [AW-1:0]           raddr;
    logic [7:0]              pix;

    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_last  = m_last_q;
    assign busy    = busy_q;

    always_ff @(posedge clk) begin
        if (state_q == LOAD && s_valid)
            fb_mem[pcnt_q] <= s_data;
    end

    // Tap fetch; with PAD=0 the window origin shifts by +1 so taps never leave the frame.
    always_comb begin
        px       = int'(cx_q) + int'(kx_q) - ((PAD != 0) ? 1 : 0);
        py       = int'(cy_q) + int'(ky_q) - ((PAD != 0) ? 1 : 0);
        in_frame = px >= 0 && px < IMG_W && py >= 0 && py < IMG_H;
        raddr    = AW'(py * IMG_W + px);
        pix      = in_frame ? fb_mem[raddr] : 8'd0;
    end

    always_comb begin
        res = '0;
        v   = '0;
        q   = '0;
        for (int f = 0; f < NUM_FILT; f++) begin
            prod[f]    = 17'($signed({1'b0, pix})) * 17'(w_q[f][k_q]);
            acc_sum[f] = acc_q[f] + ACC_W'(prod[f]);
            v          = acc_sum[f] + (ACC_W'(b_q[f]) <<< BIAS_SHIFT);
            q          = v >>> OUT_SHIFT;
            res[8*f +: 8] = v[ACC_W-1] ? 8'd0 : (|q[ACC_W-1:8]) ? 8'hFF : q[7:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        pcnt_d    = pcnt_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        k_d       = k_q;
        kx_d      = kx_q;
        ky_d      = ky_q;
        w_d       = w_q;
        b_d       = b_q;
        acc_d     = acc_q;
        s_ready_d = s_ready_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        m_data_d  = m_data_q;
        busy_d    = busy_q;
        wr        = cfg_we && !busy_q;
        last_pix  = pcnt_q == AW'(NPIX - 1);
        last_pos  = cx_q == XW'(OW - 1) && cy_q == YW'(OH - 1);
        for (int f = 0; f < NUM_FILT; f++) begin
            for (int k = 0; k < 9; k++)
                if (wr && cfg_addr == CAW'(f * 9 + k)) w_d[f][k] = cfg_data;
            if (wr && cfg_addr == CAW'(9 * NUM_FILT + f)) b_d[f] = cfg_data;
        end
        case (state_q)
            LOAD: begin
                if (s_valid) begin
                    busy_d = 1'b1;
                    pcnt_d = last_pix ? '0 : pcnt_q + 1'b1;
                    if (last_pix) begin
                        state_d   = MAC;
                        s_ready_d = 1'b0;
                        cx_d      = '0;
                        cy_d      = '0;
                        k_d       = '0;
                        kx_d      = '0;
                        ky_d      = '0;
                        acc_d     = '{default: '0};
                    end
                end
            end
            MAC: begin
                acc_d = acc_sum;
                k_d   = k_q + 1'b1;
                kx_d  = kx_q == 2'd2 ? 2'd0 : kx_q + 1'b1;
                ky_d  = kx_q == 2'd2 ? ky_q + 1'b1 : ky_q;
                if (k_q == 4'd8) begin
                    state_d   = EMIT;
                    m_valid_d = 1'b1;
                    m_data_d  = res;
                    m_last_d  = last_pos;
                    k_d       = '0;
                    kx_d      = '0;
                    ky_d      = '0;
                end
            end
            EMIT: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                    acc_d     = '{default: '0};
                    state_d   = last_pos ? LOAD : MAC;
                    s_ready_d = last_pos;
                    busy_d    = !last_pos;
                    cx_d      = cx_q == XW'(OW - 1) ? '0 : cx_q + 1'b1;
                    cy_d      = last_pos ? '0 : cx_q == XW'(OW - 1) ? cy_q + 1'b1 : cy_q;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= LOAD;
            pcnt_q    <= '0;
            cx_q      <= '0;
            cy_q      <= '0;
            k_q       <= '0;
            kx_q      <= '0;
            ky_q      <= '0;
            w_q       <= '{default: '{default: '0}};
            b_q       <= '{default: '0};
            acc_q     <= '{default: '0};
            s_ready_q <= 1'b1;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pcnt_q    <= pcnt_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            k_q       <= k_d;
            kx_q      <= kx_d;
            ky_q      <= ky_d;
            w_q       <= w_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            m_data_q  <= m_data_d;
            busy_q    <= busy_d;
        end
    end
endmodule

// File: tb/tb_conv2d_stream.sv
// tb_conv2d_stream: scoreboard bench for a PAD=1 and a PAD=0 instance of conv2d_stream.
module tb_conv2d_stream;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        sv [2], sr [2], mv [2], mr [2], ml [2], bz [2], cwe [2];
    logic [7:0]  sd [2], cd [2];
    logic [4:0]  ca [2];
    logic [15:0] md [2];
    logic [16:0] q0 [$], q1 [$];
    logic [16:0] mexp;
    logic [15:0] held [2];
    logic        stall [2];
    logic [7:0]  cf [20];
    int          beats [2];
    int          n_vec = 0, n_bad = 0;

    always #5 clk = ~clk;

    conv2d_stream #(.PAD(1)) u_same (
        .clk(clk), .rst_n(rst_n), .s_valid(sv[0]), .s_ready(sr[0]), .s_data(sd[0]),
        .m_valid(mv[0]), .m_ready(mr[0]), .m_data(md[0]), .m_last(ml[0]), .busy(bz[0]),
        .cfg_we(cwe[0]), .cfg_addr(ca[0]), .cfg_data(cd[0]));

    conv2d_stream #(.PAD(0)) u_valid (
        .clk(clk), .rst_n(rst_n), .s_valid(sv[1]), .s_ready(sr[1]), .s_data(sd[1]),
        .m_valid(mv[1]), .m_ready(mr[1]), .m_data(md[1]), .m_last(ml[1]), .busy(bz[1]),
        .cfg_we(cwe[1]), .cfg_addr(ca[1]), .cfg_data(cd[1]));

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst_n && mv[i]) begin
                if (stall[i]) begin
                    n_vec++;
                    if (md[i] !== held[i]) begin
                        n_bad++;
                        $display("FAIL hold dut%0d: data %h, required held %h", i, md[i], held[i]);
                    end
                end
                if (mr[i]) begin
                    n_vec++;
                    if ((i == 0 ? q0.size() : q1.size()) == 0) begin
                        n_bad++;
                        $display("FAIL extra_beat dut%0d: got data %h, required no beat", i, md[i]);
                    end else begin
                        if (i == 0) mexp = q0.pop_front();
                        else mexp = q1.pop_front();
                        if ({ml[i], md[i]} !== mexp) begin
                            n_bad++;
                            $display("FAIL beat%0d dut%0d: got last=%0b data=%h, required last=%0b data=%h",
                                     beats[i], i, ml[i], md[i], mexp[16], mexp[15:0]);
                        end
                        beats[i]++;
                    end
                end
                stall[i] = !mr[i];
                held[i]  = md[i];
            end else begin
                stall[i] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input int got, input int req);
        n_vec++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int sel, input int a, input logic [7:0] d);
        ca[sel]  = 5'(a);
        cd[sel]  = d;
        cwe[sel] = 1'b1;
        tick();
        cwe[sel] = 1'b0;
    endtask

    task automatic cfg_load(input int sel);
        for (int a = 0; a < 20; a++) cfg_write(sel, a, cf[a]);
    endtask

    task automatic cf_clear();
        for (int a = 0; a < 20; a++) cf[a] = 8'd0;
    endtask

    // mode 0: pixel = index, 1: all 255, 2: scrambled pattern
    task automatic send_frame(input int sel, input int mode, input bit gaps);
        for (int i = 0; i < 64; i++) begin
            if (gaps && i % 7 == 3) begin
                sv[sel] = 1'b0;
                tick();
            end
            sv[sel] = 1'b1;
            sd[sel] = mode == 0 ? 8'(i) : mode == 1 ? 8'hFF : 8'(i * 37 + 5);
            tick();
        end
        sv[sel] = 1'b0;
    endtask

    task automatic wait_done(input int sel, input int nbeats);
        int n = 0;
        while (bz[sel] && n < 3000) begin
            tick();
            n++;
        end
        check("busy_fall", int'(bz[sel]), 0);
        check("s_ready_back", int'(sr[sel]), 1);
        check("beat_count", beats[sel], nbeats);
        check("queue_drained", sel == 0 ? q0.size() : q1.size(), 0);
    endtask

    task automatic push_identity();
        for (int b = 0; b < 64; b++) q0.push_back({b == 63, 8'h00, 8'(b)});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        for (int i = 0; i < 2; i++) begin
            sv[i] = 0; sd[i] = 0; mr[i] = 1; cwe[i] = 0; ca[i] = 0; cd[i] = 0;
            beats[i] = 0; stall[i] = 0; held[i] = 0;
        end
        #2 rst_n = 1'b0;
        #3;
        check("rst_s_ready", int'(sr[0]), 1);
        check("rst_m_valid", int'(mv[0]), 0);
        check("rst_busy", int'(bz[0]), 0);
        check("rst_m_data", int'(md[0]), 0);
        check("rst_m_last", int'(ml[0]), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // identity: filter0 reproduces the pixel, out-of-range address ignored
        cf_clear();
        cf[4] = 8'd8;
        cfg_load(0);
        cfg_write(0, 31, 8'h7F);
        push_identity();
        beats[0] = 0;
        send_frame(0, 0, 0);
        check("s_ready_drop", int'(sr[0]), 0);
        n = 0;
        while (!mv[0] && n < 40) begin
            tick();
            n++;
        end
        check("first_latency", n, 9);
        wait_done(0, 64);

        // backpressure on beat 3, with input gaps during load
        push_identity();
        beats[0] = 0;
        send_frame(0, 0, 1);
        n = 0;
        while (!(mv[0] && beats[0] == 3) && n < 400) begin
            tick();
            n++;
        end
        check("bp_reach_beat3", beats[0], 3);
        mr[0] = 1'b0;
        repeat (5) begin
            tick();
            check("bp_valid", int'(mv[0]), 1);
            check("bp_data", int'(md[0][7:0]), 3);
        end
        mr[0] = 1'b1;
        wait_done(0, 64);

        // padding and saturation: filter1 all ones on an all-255 frame
        cf_clear();
        for (int a = 9; a < 18; a++) cf[a] = 8'd1;
        cfg_load(0);
        for (int b = 0; b < 64; b++) begin
            bit ex, ey;
            ex = (b % 8 == 0) || (b % 8 == 7);
            ey = (b / 8 == 0) || (b / 8 == 7);
            q0.push_back({b == 63, (ex && ey) ? 8'd127 : (ex || ey) ? 8'd191 : 8'd255, 8'h00});
        end
        beats[0] = 0;
        send_frame(0, 1, 0);
        wait_done(0, 64);

        // bias and ReLU: -1 clips to 0, +1 saturates to 255
        cf_clear();
        cf[18] = 8'hFF;
        cf[19] = 8'h01;
        cfg_load(0);
        for (int b = 0; b < 64; b++) q0.push_back({b == 63, 8'hFF, 8'h00});
        beats[0] = 0;
        send_frame(0, 2, 0);
        wait_done(0, 64);

        // PAD=0 instance with identity config; weight write while busy must not land
        cf_clear();
        cf[4] = 8'd8;
        cfg_load(1);
        for (int b = 0; b < 36; b++)
            q1.push_back({b == 35, 8'h00, 8'((b / 6 + 1) * 8 + b % 6 + 1)});
        beats[1] = 0;
        send_frame(1, 0, 0);
        cfg_write(1, 4, 8'd16);
        wait_done(1, 36);

        // asynchronous reset during MAC with the bias config still loaded on dut0
        for (int b = 0; b < 2; b++) q0.push_back({1'b0, 8'hFF, 8'h00});
        beats[0] = 0;
        send_frame(0, 2, 0);
        n = 0;
        while (beats[0] < 2 && n < 400) begin
            tick();
            n++;
        end
        check("ar_two_beats", beats[0], 2);
        tick();
        tick();
        check("ar_busy_before", int'(bz[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_m_valid", int'(mv[0]), 0);
        check("ar_busy", int'(bz[0]), 0);
        check("ar_m_data", int'(md[0]), 0);
        check("ar_s_ready", int'(sr[0]), 1);
        check("ar_queue", q0.size(), 0);
        #4 rst_n = 1'b1;
        tick();
        for (int b = 0; b < 64; b++) q0.push_back({b == 63, 16'h0000});
        beats[0] = 0;
        send_frame(0, 0, 0);
        wait_done(0, 64);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
